led_sequencer: RTL

- Upstream feeder for the LED controller inside sde_trigger. It generates LED_NOW strobes and the pulse-width field, so a calibration run of N flashes per width step over a ramp of widths needs no per-flash processor writes.
- Configured from slow-control registers. Its outputs are packed into the LED_CONTROL word in place of the processor-written LED_NOW/pulse-width bits.

---
 rtl/led_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// LED flash sequencer: issues LED_NOW strobes and a stepped pulse-width ramp to the LED controller.
// Optional build macro LED_SEQ_PPS_ALIGN_EN aligns the first flash of each width step to a PPS rising edge.
module led_sequencer #(
   parameter int PW_WIDTH     = 8,
   parameter int PERIOD_WIDTH = 24,
   parameter int COUNT_WIDTH  = 16,
   parameter int NOW_HOLD     = 4,
   parameter int MIN_PERIOD   = 512
) (
   input  logic                    CLK120,
   input  logic                    RESET,
   input  logic                    START,
   input  logic                    ABORT,
   input  logic [PW_WIDTH-1:0]     PW_START,
   input  logic [PW_WIDTH-1:0]     PW_STEP,
   input  logic [7:0]              NSTEPS,
   input  logic [COUNT_WIDTH-1:0]  NFLASH,
   input  logic [PERIOD_WIDTH-1:0] PERIOD,
   input  logic                    ONE_PPS_SYNC,
   output logic                    LED_NOW,
   output logic [PW_WIDTH-1:0]     PULSE_WIDTH,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [COUNT_WIDTH-1:0]  FLASH_COUNT
);

   typedef enum logic [2:0] {IDLE, LOAD, ALIGN, FIRE, WAIT, NEXT} state_t;

   localparam int HW = $clog2(NOW_HOLD);
   localparam logic [HW-1:0]           HOLD_LAST = HW'(NOW_HOLD - 1);
   localparam logic [HW-1:0]           HOLD_ONE  = HW'(1);
   localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] P_ONE     = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] P_TWO     = PERIOD_WIDTH'(2);
   localparam logic [PERIOD_WIDTH-1:0] P_THREE   = PERIOD_WIDTH'(3);
   localparam logic [COUNT_WIDTH-1:0]  C_ONE     = COUNT_WIDTH'(1);
   localparam logic [PW_WIDTH-1:0]     PW_MAX    = {PW_WIDTH{1'b1}};

   state_t                  state, state_n;
   logic [PW_WIDTH-1:0]     pw_step_q;
   logic [7:0]              nsteps_q;
   logic [COUNT_WIDTH-1:0]  nflash_q;
   logic [PERIOD_WIDTH-1:0] period_q;
   logic [PERIOD_WIDTH-1:0] per_cnt;
   logic [HW-1:0]           hold_cnt;
   logic [COUNT_WIDTH-1:0]  flash_in_step;
   logic [7:0]              step_cnt;
   logic [PW_WIDTH:0]       pw_sum;
   logic                    zero_cfg, more_flash, more_steps, align_ok;
   logic [PERIOD_WIDTH-1:0] wait_exit;

`ifdef LED_SEQ_PPS_ALIGN_EN
   logic pps_q;
   always_ff @(posedge CLK120) begin
      if (RESET) pps_q <= 1'b0;
      else       pps_q <= ONE_PPS_SYNC;
   end
   assign align_ok = ONE_PPS_SYNC & ~pps_q;
`else
   logic unused_pps;
   assign unused_pps = ONE_PPS_SYNC;
   assign align_ok   = 1'b1;
`endif

   assign zero_cfg   = (NSTEPS == 8'd0) || (NFLASH == '0);
   assign more_flash = flash_in_step < nflash_q;
   assign more_steps = (step_cnt + 8'd1) < nsteps_q;
   assign pw_sum     = {1'b0, PULSE_WIDTH} + {1'b0, pw_step_q};
   // A step change spends an extra cycle in ALIGN, so leave WAIT one cycle early to keep rise-to-rise spacing.
   assign wait_exit  = (!more_flash && more_steps) ? P_THREE : P_TWO;
   assign LED_NOW    = (state == FIRE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (START && !zero_cfg) state_n = LOAD;
         LOAD:  state_n = ALIGN;
         ALIGN: if (align_ok) state_n = FIRE;
         FIRE:  if (hold_cnt == HOLD_LAST) state_n = WAIT;
         WAIT:  if (per_cnt == wait_exit) state_n = NEXT;
         NEXT: begin
            if (more_flash)      state_n = FIRE;
            else if (more_steps) state_n = ALIGN;
            else                 state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (ABORT) state_n = IDLE;
   end

   always_ff @(posedge CLK120) begin
      if (RESET) begin
         state         <= IDLE;
         PULSE_WIDTH   <= '0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         FLASH_COUNT   <= '0;
         pw_step_q     <= '0;
         nsteps_q      <= '0;
         nflash_q      <= '0;
         period_q      <= '0;
         per_cnt       <= '0;
         hold_cnt      <= '0;
         flash_in_step <= '0;
         step_cnt      <= '0;
      end else begin
         state <= state_n;
         DONE  <= 1'b0;
         if (ABORT) begin
            BUSY     <= 1'b0;
            hold_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  hold_cnt <= '0;
                  if (START && zero_cfg) begin
                     DONE        <= 1'b1;
                     FLASH_COUNT <= '0;
                  end
               end
               LOAD: begin
                  pw_step_q     <= PW_STEP;
                  nsteps_q      <= NSTEPS;
                  nflash_q      <= NFLASH;
                  period_q      <= (PERIOD < MIN_P) ? MIN_P : PERIOD;
                  PULSE_WIDTH   <= PW_START;
                  FLASH_COUNT   <= '0;
                  BUSY          <= 1'b1;
                  flash_in_step <= '0;
                  step_cnt      <= '0;
               end
               FIRE: begin
                  // per_cnt holds the cycles left until the next LED_NOW rise.
                  if (hold_cnt == '0) begin
                     per_cnt       <= period_q - P_ONE;
                     FLASH_COUNT   <= FLASH_COUNT + C_ONE;
                     flash_in_step <= flash_in_step + C_ONE;
                  end else begin
                     per_cnt <= per_cnt - P_ONE;
                  end
                  hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HOLD_ONE;
               end
               WAIT: per_cnt <= per_cnt - P_ONE;
               NEXT: begin
                  per_cnt <= per_cnt - P_ONE;
                  if (!more_flash) begin
                     if (more_steps) begin
                        step_cnt      <= step_cnt + 8'd1;
                        flash_in_step <= '0;
                        PULSE_WIDTH   <= pw_sum[PW_WIDTH] ? PW_MAX : pw_sum[PW_WIDTH-1:0];
                     end else begin
                        BUSY <= 1'b0;
                        DONE <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
